// File: rtl/cdr_ctrl_pkg.sv
// cdr_ctrl_pkg: shared state encoding and default parameters for the CDR charge-pump controller
package cdr_ctrl_pkg;
  typedef enum logic [1:0] {CP_IDLE = 2'd0, CP_PRECHARGE = 2'd1, CP_TRACK = 2'd2} cp_seq_state_e;
  localparam int unsigned CP_PRECHARGE_CYC = 64;
  localparam int unsigned CP_MAX_PULSE = 16;
  localparam int unsigned CP_LOCK_WIN = 256;
  localparam int unsigned CP_LOCK_THRESH = 8;
  localparam int unsigned CP_LOCK_CNT = 4;
endpackage

// File: rtl/cp_lock_det.sv
// cp_lock_det: windowed pump-activity monitor; locked rises after LOCK_CNT consecutive quiet windows
module cp_lock_det import cdr_ctrl_pkg::*; #(
  parameter int unsigned LOCK_WIN = CP_LOCK_WIN,
  parameter int unsigned LOCK_THRESH = CP_LOCK_THRESH,
  parameter int unsigned LOCK_CNT = CP_LOCK_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic active,
  output logic locked
);
  localparam int WW = $clog2(LOCK_WIN + 1);
  localparam int AW = $clog2(LOCK_THRESH + 2);
  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(LOCK_WIN - 1);
  localparam logic [AW-1:0] ACT_MAX = AW'(LOCK_THRESH + 1);
  localparam logic [AW-1:0] ACT_OK = AW'(LOCK_THRESH);
  localparam logic [QW-1:0] Q_MAX = QW'(LOCK_CNT);
  logic [WW-1:0] win_q, win_d;
  logic [AW-1:0] act_q, act_d, act_now;
  logic [QW-1:0] quiet_q, quiet_d;
  logic locked_q, locked_d, wend, quiet;
  always_comb begin
    act_now = act_q + AW'(active && act_q != ACT_MAX);
    wend = win_q == WIN_LAST;
    quiet = act_now <= ACT_OK;
    win_d = clr || wend ? '0 : win_q + 1'b1;
    act_d = clr || wend ? '0 : act_now;
    quiet_d = clr || (wend && !quiet) ? '0 : (wend && quiet_q != Q_MAX) ? quiet_q + 1'b1 : quiet_q;
    locked_d = clr ? 1'b0 : wend ? (quiet && quiet_d == Q_MAX) : locked_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q <= '0;
      act_q <= '0;
      quiet_q <= '0;
      locked_q <= 1'b0;
    end else begin
      win_q <= win_d;
      act_q <= act_d;
      quiet_q <= quiet_d;
      locked_q <= locked_d;
    end
  assign locked = locked_q;
endmodule

// File: rtl/cp_pulse_sequencer.sv
// cp_pulse_sequencer: charge-pump sequencer with pre-charge burst, UP/DN cancel, pulse limiter and lock monitor
module cp_pulse_sequencer import cdr_ctrl_pkg::*; #(
  parameter int unsigned PRECHARGE_CYC = CP_PRECHARGE_CYC,
  parameter int unsigned MAX_PULSE = CP_MAX_PULSE,
  parameter int unsigned LOCK_WIN = CP_LOCK_WIN,
  parameter int unsigned LOCK_THRESH = CP_LOCK_THRESH,
  parameter int unsigned LOCK_CNT = CP_LOCK_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       recal,
  input  logic       pfd_up,
  input  logic       pfd_dn,
  output logic       cp_up,
  output logic       cp_dn,
  output logic       locked,
  output logic       busy,
  output logic       sat_evt,
  output logic [1:0] state_o
);
  localparam int PW = $clog2(PRECHARGE_CYC + 1);
  localparam int MW = $clog2(MAX_PULSE + 1);
  localparam logic [PW-1:0] PC_LAST = PW'(PRECHARGE_CYC - 1);
  localparam logic [MW-1:0] MAXP = MW'(MAX_PULSE);
  cp_seq_state_e state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [MW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic cp_up_q, cp_up_d, cp_dn_q, cp_dn_d;
  logic up_sat_q, up_sat_d, dn_sat_q, dn_sat_d;
  logic sat_evt_q, sat_evt_d, trk;
  always_comb begin
    state_d = !enable ? CP_IDLE :
              state_q == CP_IDLE ? CP_PRECHARGE :
              state_q == CP_PRECHARGE ? (pc_q == PC_LAST ? CP_TRACK : CP_PRECHARGE) :
              state_q == CP_TRACK ? (recal ? CP_PRECHARGE : CP_TRACK) : CP_IDLE;
    trk = state_q == CP_TRACK && state_d == CP_TRACK;
    pc_d = (state_q == CP_PRECHARGE && state_d == CP_PRECHARGE) ? pc_q + 1'b1 : '0;
    cp_up_d = state_d == CP_PRECHARGE || (trk && pfd_up && !pfd_dn && !up_sat_q);
    cp_dn_d = trk && pfd_dn && !pfd_up && !dn_sat_q;
    up_cnt_d = (trk && cp_up_d) ? up_cnt_q + 1'b1 : '0;
    dn_cnt_d = cp_dn_d ? dn_cnt_q + 1'b1 : '0;
    up_sat_d = trk && pfd_up && (up_sat_q || up_cnt_d == MAXP);
    dn_sat_d = trk && pfd_dn && (dn_sat_q || dn_cnt_d == MAXP);
    sat_evt_d = trk && (up_cnt_d == MAXP || dn_cnt_d == MAXP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CP_IDLE;
      pc_q <= '0;
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
      cp_up_q <= 1'b0;
      cp_dn_q <= 1'b0;
      up_sat_q <= 1'b0;
      dn_sat_q <= 1'b0;
      sat_evt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      up_cnt_q <= up_cnt_d;
      dn_cnt_q <= dn_cnt_d;
      cp_up_q <= cp_up_d;
      cp_dn_q <= cp_dn_d;
      up_sat_q <= up_sat_d;
      dn_sat_q <= dn_sat_d;
      sat_evt_q <= sat_evt_d;
    end
  cp_lock_det #(.LOCK_WIN(LOCK_WIN), .LOCK_THRESH(LOCK_THRESH), .LOCK_CNT(LOCK_CNT)) u_lock (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!trk),
    .active(cp_up_q || cp_dn_q),
    .locked(locked)
  );
  assign cp_up = cp_up_q;
  assign cp_dn = cp_dn_q;
  assign sat_evt = sat_evt_q;
  assign busy = state_q == CP_PRECHARGE;
  assign state_o = state_q;
endmodule
